// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read side of the async FIFO. Keeps the binary/Gray read pointer and the
// registered empty flag, and feeds a registered first-word-fall-through valid/ready stage.
module fifo_rd_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  rclk,
   input  logic                  rrst,
   input  logic [ADDR_WIDTH:0]   rq2_wptr,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic [ADDR_WIDTH:0]   rptr,
   output logic                  rempty,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic [ADDR_WIDTH:0]   rlevel
);
   logic [ADDR_WIDTH:0] rbin, rbin_next, rgray_next, wbin;
   logic                pop;
   // the stage refills whenever it is empty or its word leaves this cycle
   assign pop        = ~rempty & (~m_valid | m_ready);
   assign rbin_next  = rbin + {{ADDR_WIDTH{1'b0}}, pop};
   assign rgray_next = rbin_next ^ (rbin_next >> 1);
   assign raddr      = rbin[ADDR_WIDTH-1:0];
   assign rlevel     = wbin - rbin;
   always_comb begin
      wbin = '0;
      for (int i = 0; i <= ADDR_WIDTH; i++) wbin[i] = ^(rq2_wptr >> i);
   end
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         rbin    <= '0;
         rptr    <= '0;
         rempty  <= 1'b1;
         m_valid <= 1'b0;
         m_data  <= '0;
      end else begin
         rbin    <= rbin_next;
         rptr    <= rgray_next;
         rempty  <= rgray_next == rq2_wptr;
         m_valid <= pop | (m_valid & ~m_ready);
         m_data  <= pop ? rdata : m_data;
      end
   end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed bench for the FIFO read controller with a behavioural fifo_mem.
module tb_fifo_rd_ctrl;
   logic        rclk, rrst, m_ready, rempty, m_valid;
   logic [4:0]  rq2_wptr, rptr, rlevel, prev;
   logic [3:0]  raddr;
   logic [31:0] rdata, m_data;
   logic [31:0] mem [16];
   int checks, errors, wn, beats;

   fifo_rd_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
      .rclk(rclk), .rrst(rrst), .rq2_wptr(rq2_wptr), .rdata(rdata), .raddr(raddr),
      .rptr(rptr), .rempty(rempty), .m_valid(m_valid), .m_data(m_data),
      .m_ready(m_ready), .rlevel(rlevel)
   );

   assign rdata = mem[raddr];

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] gray(input int n);
      logic [4:0] b;
      b = n[4:0];
      return b ^ (b >> 1);
   endfunction

   task automatic set_w(input int n);
      wn = n;
      rq2_wptr = gray(n);
   endtask

   task automatic step;
      @(negedge rclk);
   endtask

   task automatic do_reset;
      rrst = 1'b1;
      m_ready = 1'b0;
      set_w(0);
      step;
      rrst = 1'b0;
      step;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rrst = 1'b1;
      m_ready = 1'b0;
      set_w(0);
      for (int i = 0; i < 16; i++) mem[i] = '0;
      step;
      check("t1_rempty", 64'(rempty), 64'(1));
      check("t1_m_valid", 64'(m_valid), 64'(0));
      check("t1_raddr", 64'(raddr), 64'(0));
      check("t1_rptr", 64'(rptr), 64'(0));
      check("t1_rlevel", 64'(rlevel), 64'(0));
      rrst = 1'b0;
      step;

      mem[0] = 32'hA5A5_0001;
      m_ready = 1'b1;
      set_w(1);
      #1 check("t2_rlevel_1", 64'(rlevel), 64'(1));
      step;
      check("t2_rempty_fall", 64'(rempty), 64'(0));
      check("t2_valid_early", 64'(m_valid), 64'(0));
      step;
      check("t2_m_valid", 64'(m_valid), 64'(1));
      check("t2_m_data", 64'(m_data), 64'(32'hA5A5_0001));
      check("t2_rempty_set", 64'(rempty), 64'(1));
      check("t2_rptr", 64'(rptr), 64'(5'b00001));
      check("t2_rlevel_0", 64'(rlevel), 64'(0));
      step;
      check("t2_valid_drop", 64'(m_valid), 64'(0));

      do_reset;
      for (int i = 0; i < 16; i++) mem[i] = 32'hB000_0000 + i;
      m_ready = 1'b1;
      set_w(16);
      beats = 0;
      #1 check("t3_rlevel_start", 64'(rlevel), 64'(16));
      for (int j = 1; j <= 18; j++) begin
         step;
         check("t3_m_valid", 64'(m_valid), 64'(j >= 2 && j <= 17));
         check("t3_rlevel", 64'(rlevel), 64'(j <= 1 ? 16 : (j >= 17 ? 0 : 17 - j)));
         if (m_valid) begin
            check("t3_m_data", 64'(m_data), 64'(32'hB000_0000 + (j - 2)));
            beats++;
         end
      end
      check("t3_beats", 64'(beats), 64'(16));
      check("t3_rempty", 64'(rempty), 64'(1));

      do_reset;
      for (int i = 0; i < 4; i++) mem[i] = 32'hD000_0000 + i;
      set_w(4);
      step;
      for (int k = 0; k < 5; k++) begin
         step;
         check("t4_hold_valid", 64'(m_valid), 64'(1));
         check("t4_hold_data", 64'(m_data), 64'(32'hD000_0000));
         check("t4_raddr", 64'(raddr), 64'(1));
         check("t4_rlevel", 64'(rlevel), 64'(3));
      end
      m_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("t4_beat_valid", 64'(m_valid), 64'(1));
         check("t4_beat_data", 64'(m_data), 64'(32'hD000_0000 + k));
         step;
      end
      check("t4_valid_drop", 64'(m_valid), 64'(0));
      check("t4_rempty", 64'(rempty), 64'(1));

      do_reset;
      m_ready = 1'b1;
      beats = 0;
      prev = 5'b0;
      for (int c = 0; c < 300 && beats < 40; c++) begin
         step;
         if (m_valid) begin
            check("t5_data_order", 64'(m_data), 64'(32'hC000_0000 + beats));
            beats++;
         end
         if (rptr != prev) check("t5_gray_1bit", 64'($countones(rptr ^ prev)), 64'(1));
         prev = rptr;
         if (wn < 40 && wn - beats < 15) begin
            mem[wn[3:0]] = 32'hC000_0000 + wn;
            set_w(wn + 1);
         end
      end
      check("t5_beats", 64'(beats), 64'(40));
      check("t5_raddr", 64'(raddr), 64'(8));
      check("t5_rptr", 64'(rptr), 64'(5'b01100));
      check("t5_rempty", 64'(rempty), 64'(1));

      do_reset;
      for (int i = 0; i < 16; i++) mem[i] = 32'hE000_0000 + i;
      m_ready = 1'b1;
      set_w(16);
      for (int j = 1; j <= 8; j++) step;
      check("t6_beat7_data", 64'(m_data), 64'(32'hE000_0006));
      rrst = 1'b1;
      #1;
      check("t6_async_valid", 64'(m_valid), 64'(0));
      check("t6_async_data", 64'(m_data), 64'(0));
      check("t6_async_raddr", 64'(raddr), 64'(0));
      check("t6_async_rptr", 64'(rptr), 64'(0));
      check("t6_async_rlevel", 64'(rlevel), 64'(16));
      set_w(0);
      step;
      rrst = 1'b0;
      step;
      step;
      check("t6_rempty", 64'(rempty), 64'(1));
      check("t6_m_valid", 64'(m_valid), 64'(0));
      check("t6_rlevel", 64'(rlevel), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
